pq_bist: RTL and testbench
==========================

PQ_BIST -- requirements
Module: pq_bist

Interface
REQ-001 Parameter SETTLE_CYCLES SHALL default to 2 and set the wait cycles between driving a vector and sampling the response (legal range 1..15).
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port start  input  1  SHALL be a run request, sampled only in IDLE and DONE.
REQ-005 Port p_in  input  1  SHALL carry the P response from the function under test.
REQ-006 Port q_in  input  1  SHALL carry the Q response from the function under test.
REQ-007 Port a_out, b_out, c_out  output  1 each  SHALL drive the stimulus vector {A,B,C} to the function under test.
REQ-008 Port busy  output  1  SHALL be high while a sweep is in progress.
REQ-009 Port done  output  1  SHALL be high in DONE only.
REQ-010 Port pass  output  1  SHALL be high in DONE when fail_count==0.
REQ-011 Port fail_count  output  4  SHALL hold the number of mismatching vectors (0..8).
REQ-012 Port first_fail_vec  output  3  SHALL hold the {A,B,C} of the first mismatch; it SHALL be 3'b000 when no mismatch has occurred.

Function
REQ-013 The block SHALL compare responses against the golden table {P,Q}: 000->01, 001->11, 010->01, 011->00, 100->10, 101->10, 110->00, 111->00.
REQ-014 The FSM SHALL have four states: IDLE, SETTLE, CHECK and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL go to SETTLE on the next edge with vec=000, settle counter=0, fail_count=0, first_fail_vec=000, done=0 and busy=1.
REQ-016 SETTLE SHALL drive {a_out,b_out,c_out}=vec and last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-017 CHECK SHALL last one cycle, sample {p_in,q_in}, and on mismatch increment fail_count.
REQ-018 If the mismatch in CHECK is the first one, CHECK SHALL also capture vec into first_fail_vec.
REQ-019 From CHECK, if vec==3'b111 the FSM SHALL go to DONE; otherwise vec SHALL increment by 1 and the FSM SHALL return to SETTLE.
REQ-020 vec SHALL never wrap past 3'b111 within a sweep.
REQ-021 Latency SHALL be 8*(SETTLE_CYCLES+1) cycles from the start-accept edge to the first cycle with done=1 (24 with the default).
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 start held high in DONE SHALL re-launch a sweep on the next edge.
REQ-024 DONE SHALL hold done, pass, fail_count and first_fail_vec stable until start or reset.
REQ-025 In DONE, stimulus outputs SHALL hold 3'b111.
REQ-026 fail_count SHALL saturate at 8 and never wrap.

Reset
REQ-027 reset=1 SHALL, at the next clock edge and in any state (including mid-sweep), force IDLE with a_out=b_out=c_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_vec=000 and settle counter=0.
REQ-028 reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro PQ_BIST_STOP_ON_FAIL_EN, when defined, SHALL make CHECK go directly to DONE on the first mismatch, with fail_count=1 and pass=0.
REQ-030 Without PQ_BIST_STOP_ON_FAIL_EN, all 8 vectors SHALL always be checked.

Structure
REQ-031 Package pq_bist_pkg SHALL hold the state enum, NUM_VECTORS=8, and the golden table as an 8-entry array of 2-bit constants.
REQ-032 Sub-module pq_golden SHALL be a combinational lookup of 3-bit vec to the 2-bit expected {P,Q}, instantiated once.

Verification
REQ-033 Correct P/Q model, SETTLE_CYCLES=2, start pulse -> done=1 24 cycles later, pass=1, fail_count=0, first_fail_vec=000.
REQ-034 Q stuck-at-0 -> fail_count=3, first_fail_vec=000, pass=0.
REQ-035 P stuck-at-1 -> fail_count=5 (vectors 000,010,011,110,111), first_fail_vec=000.
REQ-036 P/Q swapped -> fail_count=4 (000,010,100,101), first_fail_vec=000.
REQ-037 start pulsed at cycle 5 of a sweep -> ignored, done still at cycle 24; reset at cycle 10 -> IDLE next edge, all outputs zero, done never asserted.
REQ-038 With PQ_BIST_STOP_ON_FAIL_EN and Q stuck-at-0 -> done=1 3 cycles after start, fail_count=1, first_fail_vec=000.

Source files
------------

// File: rtl/pq_bist_pkg.sv
// Shared types and constants for the P/Q built-in self-test block.
package pq_bist_pkg;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned RESP_W      = 2;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned FAIL_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Expected {P,Q} response, indexed by the {A,B,C} stimulus vector.
  localparam logic [RESP_W-1:0] GOLDEN [NUM_VECTORS] = '{
    2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00
  };

endpackage

// File: rtl/pq_golden.sv
// Combinational lookup of the expected {P,Q} response for a stimulus vector.
module pq_golden
  import pq_bist_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  output logic [RESP_W-1:0] expected
);

  // Table read; every 3-bit index is a valid entry.
  always_comb begin
    expected = GOLDEN[vec];
  end

endmodule

// File: rtl/pq_bist.sv
// Self-test sweep of a 3-input / 2-output function against a golden table.
// Optional build macro PQ_BIST_STOP_ON_FAIL_EN ends the sweep on the first
// mismatching vector instead of checking all eight.
module pq_bist
  import pq_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              p_in,
  input  logic              q_in,
  output logic              a_out,
  output logic              b_out,
  output logic              c_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FAIL_W-1:0] fail_count,
  output logic [VEC_W-1:0]  first_fail_vec
);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(NUM_VECTORS);
  localparam logic [VEC_W-1:0]  VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

  state_t              state, state_next;
  logic [VEC_W-1:0]    vec, vec_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [FAIL_W-1:0]   fail_next;
  logic [VEC_W-1:0]    first_fail_next;
  logic [RESP_W-1:0]   expected;
  logic                mismatch;
  logic                busy_next, done_next, pass_next;
  logic [VEC_W-1:0]    stim_next;

  pq_golden u_golden (
    .vec      (vec),
    .expected (expected)
  );

  assign mismatch = ({p_in, q_in} != expected);

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      vec            <= '0;
      cnt            <= '0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      a_out          <= 1'b0;
      b_out          <= 1'b0;
      c_out          <= 1'b0;
    end else begin
      state                 <= state_next;
      vec                   <= vec_next;
      cnt                   <= cnt_next;
      fail_count            <= fail_next;
      first_fail_vec        <= first_fail_next;
      busy                  <= busy_next;
      done                  <= done_next;
      pass                  <= pass_next;
      {a_out, b_out, c_out} <= stim_next;
    end
  end

  // Next-state and datapath update: settle, compare, advance.
  always_comb begin
    state_next      = state;
    vec_next        = vec;
    cnt_next        = cnt;
    fail_next       = fail_count;
    first_fail_next = first_fail_vec;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next      = ST_SETTLE;
          vec_next        = '0;
          cnt_next        = '0;
          fail_next       = '0;
          first_fail_next = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_next = ST_CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (fail_count < FAIL_MAX) fail_next = fail_count + FAIL_W'(1);
          if (fail_count == '0) first_fail_next = vec;
        end
`ifdef PQ_BIST_STOP_ON_FAIL_EN
        if (mismatch || vec == VEC_LAST) begin
`else
        if (vec == VEC_LAST) begin
`endif
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          vec_next   = vec + VEC_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs leave a register.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    pass_next = 1'b0;
    stim_next = '0;
    case (state_next)
      ST_SETTLE, ST_CHECK: begin
        busy_next = 1'b1;
        stim_next = vec_next;
      end
      ST_DONE: begin
        done_next = 1'b1;
        pass_next = (fail_next == '0);
        stim_next = VEC_LAST;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pq_bist.sv
// Directed bench for pq_bist with a behavioural function under test that can
// be switched between correct and several faulty response patterns.
module tb_pq_bist;

  logic       clk;
  logic       reset;
  logic       start;
  logic       p_in, q_in;
  logic       a_out, b_out, c_out;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail_vec;

  int n_cmp  = 0;
  int n_fail = 0;
  int mode   = 0;

  pq_bist #(.SETTLE_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .p_in           (p_in),
    .q_in           (q_in),
    .a_out          (a_out),
    .b_out          (b_out),
    .c_out          (c_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference function: 0 correct, 1 Q stuck-0, 2 P stuck-1, 3 P/Q swapped,
  // 4 P inverted on vector 101 only.
  function automatic logic [1:0] ref_pq(input logic [2:0] v);
    case (v)
      3'd0: ref_pq = 2'b01;
      3'd1: ref_pq = 2'b11;
      3'd2: ref_pq = 2'b01;
      3'd3: ref_pq = 2'b00;
      3'd4: ref_pq = 2'b10;
      3'd5: ref_pq = 2'b10;
      default: ref_pq = 2'b00;
    endcase
  endfunction

  always_comb begin
    logic [1:0] r;
    logic [2:0] v;
    v = {a_out, b_out, c_out};
    r = ref_pq(v);
    case (mode)
      1: r = {r[1], 1'b0};
      2: r = {1'b1, r[0]};
      3: r = {r[0], r[1]};
      4: if (v == 3'b101) r = {~r[1], r[0]};
      default: ;
    endcase
    {p_in, q_in} = r;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept a start, optionally pulse start again mid-sweep, return latency.
  task automatic run_sweep(input int pulse_at, output int lat);
    int cycles;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    check("done_after_accept", done, 0);
    cycles = 0;
    while (!done && cycles < 200) begin
      start = (cycles == pulse_at);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    lat = cycles;
  endtask

  task automatic sweep_and_check(input string tag, input int m, input int exp_lat,
                                 input int exp_fail, input int exp_first);
    int lat;
    mode = m;
    run_sweep(-1, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fail_count"}, fail_count, exp_fail);
    check({tag, "_first_fail"}, first_fail_vec, exp_first);
    check({tag, "_pass"}, pass, (exp_fail == 0) ? 1 : 0);
    check({tag, "_stim_111"}, {a_out, b_out, c_out}, 7);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, done, 1);
    check({tag, "_hold_fail"}, fail_count, exp_fail);
  endtask

  initial begin
    int lat;
    int seen_done;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_first_fail", first_fail_vec, 0);
    check("rst_stim", {a_out, b_out, c_out}, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_prio_busy", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

`ifdef PQ_BIST_STOP_ON_FAIL_EN
    sweep_and_check("correct",  0, 24, 0, 0);
    sweep_and_check("q_sa0",    1,  3, 1, 0);
    sweep_and_check("p_sa1",    2,  3, 1, 0);
    sweep_and_check("swap",     3,  3, 1, 0);
    sweep_and_check("p_bad101", 4, 18, 1, 5);
`else
    sweep_and_check("correct",  0, 24, 0, 0);
    sweep_and_check("q_sa0",    1, 24, 3, 0);
    sweep_and_check("p_sa1",    2, 24, 5, 0);
    sweep_and_check("swap",     3, 24, 4, 0);
    sweep_and_check("p_bad101", 4, 24, 1, 5);
`endif

    // Start held high in DONE relaunches and clears the result.
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("relaunch_busy", busy, 1);
    check("relaunch_done", done, 0);
    check("relaunch_fail_cleared", fail_count, 0);
    check("relaunch_first_cleared", first_fail_vec, 0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("relaunch_latency", lat, 24);
    check("relaunch_pass", pass, 1);

    // Start pulsed mid-sweep is ignored.
    run_sweep(5, lat);
    check("ignore_start_latency", lat, 24);
    check("ignore_start_pass", pass, 1);

    // Reset mid-sweep returns to IDLE and no done follows.
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_sweep_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_fail_count", fail_count, 0);
    check("midrst_first_fail", first_fail_vec, 0);
    check("midrst_stim", {a_out, b_out, c_out}, 0);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1;
    end
    check("midrst_stays_idle", seen_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
